// File: rtl/riscv_if_id.sv
// IF->ID elastic pipeline register: 2-entry skid FIFO carrying {instr, pc, pc4} from fetch to decode.
// Latency: 1 cycle from an accepted push into an empty buffer to the entry being presented to ID.
// Backpressure: o_IF_ready depends only on occupancy (low when full), so ID ready never reaches IF combinationally.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_if_id (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_IF_valid,
    output logic              o_IF_ready,
    input  logic [`XLEN-1:0]  i_IF_instr,
    input  logic [`XLEN-1:0]  i_IF_pc,
    input  logic [`XLEN-1:0]  i_IF_pc4,
    output logic              o_ID_valid,
    input  logic              i_ID_ready,
    output logic [`XLEN-1:0]  o_ID_instr,
    output logic [`XLEN-1:0]  o_ID_pc,
    output logic [`XLEN-1:0]  o_ID_pc4,
    output logic [1:0]        o_IF_ID_cnt
);

    localparam logic [`XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    typedef struct packed {
        logic [`XLEN-1:0] instr;
        logic [`XLEN-1:0] pc;
        logic [`XLEN-1:0] pc4;
    } entry_t;

    logic [1:0] state;
    entry_t     head;
    entry_t     tail;
    entry_t     in_entry;
    logic       push;
    logic       pop;

    assign in_entry = '{instr: i_IF_instr, pc: i_IF_pc, pc4: i_IF_pc4};

    assign o_IF_ready  = (state != S_FULL) & ~i_rst;
    assign o_ID_valid  = (state != S_EMPTY);
    assign push        = i_IF_valid & o_IF_ready;
    assign pop         = o_ID_valid & i_ID_ready;
    assign o_IF_ID_cnt = state;

    // Invalid slots present a harmless NOP so decode never sees stale data.
    assign o_ID_instr = o_ID_valid ? head.instr : NOP_INSTR;
    assign o_ID_pc    = o_ID_valid ? head.pc    : '0;
    assign o_ID_pc4   = o_ID_valid ? head.pc4   : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else if (i_flush) begin
            state <= S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (push) begin
                        head  <= in_entry;
                        state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head <= in_entry;
                    end else if (push) begin
                        tail  <= in_entry;
                        state <= S_FULL;
                    end else if (pop) begin
                        state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        head  <= tail;
                        state <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: doc/riscv_if_id.md
# riscv_IF_ID

Elastic IF→ID pipeline register. Sits directly downstream of the instruction-fetch stage: it captures the fetched instruction, its PC and PC+4 under a valid/ready handshake and presents them to the decode stage. A 2-entry skid buffer gives full throughput without a combinational ready path from ID back to IF. A flush input squashes all buffered fetches on a control-flow redirect.

## Interface
- NOP_INSTR, 32'h0000_0013, instruction word driven on o_ID_instr while no valid entry is presented (addi x0,x0,0)
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_flush  in  1  discard all buffered entries; same-cycle push ignored
- i_IF_valid  in  1  IF presents a fetched instruction
- o_IF_ready  out  1  buffer accepts a push this cycle
- i_IF_instr  in  `XLEN  fetched instruction
- i_IF_pc  in  `XLEN  PC of fetched instruction
- i_IF_pc4  in  `XLEN  PC+4 from IF adder
- o_ID_valid  out  1  head entry valid for decode
- i_ID_ready  in  1  decode accepts head entry
- o_ID_instr  out  `XLEN  head instruction, NOP_INSTR when invalid
- o_ID_pc  out  `XLEN  head PC, 0 when invalid
- o_ID_pc4  out  `XLEN  head PC+4, 0 when invalid
- o_IF_ID_cnt  out  2  occupancy 0..2

## Operation
- Storage: two entries {instr, pc, pc4} as FIFO (head/tail), state EMPTY / ONE / FULL; o_IF_ID_cnt = 0/1/2.
- push = i_IF_valid & o_IF_ready; pop = o_ID_valid & i_ID_ready.
- o_IF_ready = (state != FULL) & ~i_rst; no dependence on i_ID_ready or i_IF_valid.
- o_ID_valid = (state != EMPTY); o_ID_* driven from head entry register, no combinational path from i_IF_*.
- Transitions:
  - EMPTY: push → ONE (entry written as head).
  - ONE: push&~pop → FULL; pop&~push → EMPTY; push&pop → ONE, new entry becomes head.
  - FULL: pop → ONE, second entry becomes head; push impossible (ready low).
- Priority: i_rst > i_flush > push/pop.
- i_flush: next state EMPTY regardless of push/pop; pop in flush cycle is still a completed transfer from the ID side (ID handles its own kill), push in flush cycle is discarded.
- Order strictly preserved: pop order equals push order; no entry duplicated or dropped except by flush/reset.
- Data held stable while o_ID_valid & ~i_ID_ready.
- o_ID_pc4 is carried, never recomputed.

## Timing
- Reset (i_rst high at edge): state EMPTY, cnt 0, entry registers cleared to 0; next cycle o_ID_valid 0, o_ID_instr NOP_INSTR, o_ID_pc/pc4 0, o_IF_ready 1. While i_rst high, o_IF_ready 0.
- Reset mid-operation: all entries lost, same values as above after the edge.
- Latency: push at edge N (from EMPTY) → o_ID_valid and data at N+1 (1 cycle).
- Throughput: 1 entry/cycle sustained with i_ID_ready held 1; ONE state maintained with simultaneous push/pop.
- Backpressure: i_ID_ready low for k cycles with continuous IF valid → at most 2 entries accepted, o_IF_ready low from edge after second push until edge after first pop.
- Flush: at edge with i_flush=1 → next cycle o_ID_valid 0, cnt 0, o_IF_ready 1.
- Full + pop same cycle: no push (ready already low); ready returns next cycle.

## Test plan
- Reset: hold i_rst 2 cycles with i_IF_valid=1 → o_IF_ready 0 during reset, afterwards o_ID_valid 0, o_ID_instr 32'h00000013, cnt 0, no entry captured.
- Streaming: push pc=0x0,0x4,0x8,0xC (instr 0x00500093 etc.), i_ID_ready=1 → each appears one cycle after push, in order, o_ID_pc4 = pc+4, cnt stays 1.
- Backpressure: i_ID_ready=0, push pc 0x100,0x104,0x108 continuously → only 0x100,0x104 accepted, o_IF_ready 0, cnt 2; release ready → pops 0x100 then 0x104, then 0x108 accepted and popped; no loss/duplication.
- Flush in FULL: cnt 2, assert i_flush with i_IF_valid=1 pc 0x200 → next cycle cnt 0, o_ID_valid 0, 0x200 not captured; next push 0x300 emerges one cycle later.
- Simultaneous push/pop in ONE: head 0x40, push 0x44 with i_ID_ready=1 → next cycle head 0x44, cnt 1.
- Random: random i_IF_valid/i_ID_ready/i_flush 10k cycles vs scoreboard FIFO model → order, occupancy ≤2, stability under stall all hold.
